// File: rtl/curr_row_deser.sv
// Packs IN_PIX-pixel beats into 8/16/32-pixel rows for the SAD array, tagging row index and last row.
// Latency: a row's final beat accepted in cycle t gives out_valid in t+1; in_ready drops only when both the assembly and output registers are full.
module curr_row_deser #(
    parameter int PIXEL   = 8,
    parameter int IN_PIX  = 2,
    parameter int ROW_PIX = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   blk_size,
    input  logic                         in_valid,
    input  logic [IN_PIX*PIXEL-1:0]      in_pixels,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROW_PIX*PIXEL-1:0]     out_pixels,
    output logic [$clog2(ROW_PIX)-1:0]   out_row_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int BEAT_W  = IN_PIX * PIXEL;
    localparam int ROW_W   = ROW_PIX * PIXEL;
    localparam int IDX_W   = $clog2(ROW_PIX);
    localparam int MAX_BPR = ROW_PIX / IN_PIX;
    localparam int BCNT_W  = (MAX_BPR > 1) ? $clog2(MAX_BPR) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  w_m1_q;
    logic [IDX_W-1:0]  row_cnt_q;
    logic [IDX_W-1:0]  fill_cnt_q;
    logic [BCNT_W-1:0] bpr_m1_q;
    logic [BCNT_W-1:0] beat_cnt_q;
    logic [ROW_W-1:0]  asm_q;
    logic [ROW_W-1:0]  asm_d;
    logic              row_full_q;
    logic              feed_done_q;

    int                w_sel;
    logic [IDX_W-1:0]  w_m1_new;
    logic [BCNT_W-1:0] bpr_m1_new;

    logic accept;
    logic complete;
    logic out_free;
    logic xfer;
    logic consume;
    logic final_consume;

    always_comb begin
        w_sel = ROW_PIX;
        case (blk_size)
            2'd0:    w_sel = 8;
            2'd1:    w_sel = 16;
            2'd2:    w_sel = 32;
            default: w_sel = ROW_PIX;
        endcase
        if (w_sel > ROW_PIX) begin
            w_sel = ROW_PIX;
        end
        w_m1_new   = IDX_W'(w_sel - 1);
        bpr_m1_new = BCNT_W'(w_sel / IN_PIX - 1);
    end

    assign busy          = (state_q == S_RUN);
    assign accept        = in_valid && in_ready && !start;
    assign complete      = accept && (beat_cnt_q == bpr_m1_q);
    assign out_free      = !out_valid || out_ready;
    // A row parked in the assembly register always leaves before a newly completed one.
    assign xfer          = busy && out_free && (row_full_q || complete);
    assign consume       = out_valid && out_ready;
    assign final_consume = consume && out_last;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = !feed_done_q && !(row_full_q && out_valid && !out_ready);
                if (start) begin
                    state_d = S_RUN;
                end else if (final_consume) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d[int'(beat_cnt_q) * BEAT_W +: BEAT_W] = in_pixels;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_m1_q      <= '0;
            bpr_m1_q    <= '0;
            row_cnt_q   <= '0;
            fill_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            row_full_q  <= 1'b0;
            feed_done_q <= 1'b0;
            out_valid   <= 1'b0;
            out_pixels  <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            w_m1_q      <= w_m1_new;
            bpr_m1_q    <= bpr_m1_new;
            row_cnt_q   <= '0;
            fill_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            row_full_q  <= 1'b0;
            feed_done_q <= 1'b0;
            out_valid   <= 1'b0;
            out_pixels  <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done  <= 1'b0;
            asm_q <= asm_d;

            if (accept) begin
                beat_cnt_q <= complete ? '0 : beat_cnt_q + BCNT_W'(1);
            end

            if (complete) begin
                fill_cnt_q <= fill_cnt_q + IDX_W'(1);
                if (fill_cnt_q == w_m1_q) begin
                    feed_done_q <= 1'b1;
                end
            end

            if (xfer) begin
                row_full_q <= row_full_q && complete;
            end else if (complete) begin
                row_full_q <= 1'b1;
            end

            if (xfer) begin
                out_pixels  <= row_full_q ? asm_q : asm_d;
                out_row_idx <= row_cnt_q;
                out_last    <= (row_cnt_q == w_m1_q);
                out_valid   <= 1'b1;
                row_cnt_q   <= row_cnt_q + IDX_W'(1);
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            if (final_consume) begin
                done        <= 1'b1;
                row_cnt_q   <= '0;
                fill_cnt_q  <= '0;
                beat_cnt_q  <= '0;
                feed_done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_curr_row_deser.sv
// Randomised bench for curr_row_deser: expected rows come from per-block pixel arrays,
// a negedge monitor pops and compares every accepted row, done pulse and idle in_ready.
module tb_curr_row_deser;

    localparam int PIXEL   = 8;
    localparam int IN_PIX  = 2;
    localparam int ROW_PIX = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   blk_size;
    logic         in_valid;
    logic [15:0]  in_pixels;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_pixels;
    logic [4:0]   out_row_idx;
    logic         out_last;
    logic         busy;
    logic         done;

    curr_row_deser #(.PIXEL(PIXEL), .IN_PIX(IN_PIX), .ROW_PIX(ROW_PIX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .blk_size    (blk_size),
        .in_valid    (in_valid),
        .in_pixels   (in_pixels),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixels  (out_pixels),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] pix;
        int           idx;
        bit           last;
    } row_t;

    row_t       exp_q[$];
    logic [7:0] blk_pix [0:1023];
    int         cur_w;
    int         cur_bpr;
    int         errors = 0;
    int         checks = 0;
    bit         ready_rand  = 1'b0;
    bit         ready_fixed = 1'b1;
    bit         lat_mode    = 1'b0;
    bit         done_due    = 1'b0;
    bit         lat_pending = 1'b0;
    int         bcnt        = 0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_rand ? 1'($urandom % 2) : ready_fixed;
        end
    end

    // Scoreboard monitor: everything here is sampled at the falling edge.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due    = 1'b0;
                lat_pending = 1'b0;
                bcnt        = 0;
            end else begin
                if (done_due || done) begin
                    chk("done_pulse", 256'(done), 256'(done_due));
                    if (done_due) chk("busy_at_done", 256'(busy), 256'(0));
                end
                done_due = 1'b0;
                if (!busy) chk("in_ready_idle", 256'(in_ready), 256'(0));
                if (lat_pending) begin
                    if (lat_mode) chk("row_latency", 256'(out_valid), 256'(1));
                    lat_pending = 1'b0;
                end
                if (start) begin
                    bcnt = 0;
                end else if (in_valid && in_ready) begin
                    bcnt++;
                    if (bcnt == cur_bpr) begin
                        bcnt        = 0;
                        lat_pending = 1'b1;
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: got row %0d expected no row", out_row_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_pixels", out_pixels, e.pix);
                        chk("row_idx", 256'(out_row_idx), 256'(e.idx));
                        chk("row_last", 256'(out_last), 256'(e.last));
                        if (e.last) done_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start_block(input int bs, input bit rnd, input bit junk);
        cur_w   = ((8 << bs) > ROW_PIX) ? ROW_PIX : (8 << bs);
        cur_bpr = cur_w / IN_PIX;
        for (int p = 0; p < cur_w * cur_w; p++) begin
            blk_pix[p] = rnd ? 8'($urandom) : 8'(p);
        end
        for (int r = 0; r < cur_w; r++) begin
            row_t e;
            e.pix = '0;
            for (int k = 0; k < cur_w; k++) begin
                e.pix[k*8 +: 8] = blk_pix[r*cur_w + k];
            end
            e.idx  = r;
            e.last = (r == cur_w - 1);
            exp_q.push_back(e);
        end
        start     = 1'b1;
        blk_size  = 2'(bs);
        in_valid  = junk;
        in_pixels = 16'hA5C3;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_beat(input int b);
        bit acc;
        bit ok;
        ok        = 1'b0;
        in_pixels = {blk_pix[2*b+1], blk_pix[2*b]};
        in_valid  = 1'b1;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            ok = acc;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat %0d not accepted, required within 400 cycles", b);
        end
    endtask

    task automatic feed(input int first, input int n, input bit rvalid);
        for (int b = first; b < first + n; b++) begin
            if (rvalid) begin
                while ($urandom % 2 == 1) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(b);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("block_busy_cleared", 256'(busy), 256'(0));
        chk("rows_outstanding", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_out_pixels"}, out_pixels, 256'(0));
        chk({tag, "_out_row_idx"}, 256'(out_row_idx), 256'(0));
        chk({tag, "_out_last"}, 256'(out_last), 256'(0));
    endtask

    initial begin
        logic [255:0] row0;
        rst_n     = 1'b0;
        start     = 1'b0;
        blk_size  = 2'd0;
        in_valid  = 1'b0;
        in_pixels = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beats while idle must be refused.
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // 32x32 free flow with the counting pattern.
        lat_mode = 1'b1;
        start_block(2, 1'b0, 1'b0);
        chk("start_busy", 256'(busy), 256'(1));
        chk("start_out_valid", 256'(out_valid), 256'(0));
        feed(0, 512, 1'b0);
        wait_idle();

        // 8x8 free flow, junk beat in the start cycle.
        start_block(0, 1'b1, 1'b1);
        feed(0, 32, 1'b0);
        wait_idle();
        lat_mode = 1'b0;

        // Backpressure: row 0 parked, row 1 fills the assembly register.
        ready_fixed = 1'b0;
        start_block(2, 1'b1, 1'b0);
        row0 = exp_q[0].pix;
        feed(0, 16, 1'b0);
        feed(16, 16, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        chk("bp_out_valid", 256'(out_valid), 256'(1));
        chk("bp_row0_idx", 256'(out_row_idx), 256'(0));
        chk("bp_row0_stable", out_pixels, row0);
        repeat (5) @(negedge clk);
        chk("bp_row0_still_stable", out_pixels, row0);
        chk("bp_in_ready_still_low", 256'(in_ready), 256'(0));
        ready_fixed = 1'b1;
        @(posedge clk);
        #3;
        chk("bp_in_ready_back", 256'(in_ready), 256'(1));
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_row1_valid", 256'(out_valid), 256'(1));
        chk("bp_row1_idx", 256'(out_row_idx), 256'(1));
        feed(32, 480, 1'b0);
        wait_idle();

        // Random valid/ready, 16x16.
        ready_rand = 1'b1;
        start_block(1, 1'b1, 1'b0);
        feed(0, 128, 1'b1);
        wait_idle();
        ready_rand = 1'b0;
        @(posedge clk);
        #1;

        // Abort in the middle of row 5 with row 4 parked at the output.
        start_block(0, 1'b1, 1'b0);
        feed(0, 19, 1'b0);
        ready_fixed = 1'b0;
        feed(19, 1, 1'b0);
        feed(20, 2, 1'b0);
        @(negedge clk);
        chk("abort_pre_valid", 256'(out_valid), 256'(1));
        chk("abort_pre_idx", 256'(out_row_idx), 256'(4));
        @(posedge clk);
        #1;
        exp_q.delete();
        start_block(0, 1'b1, 1'b1);
        chk("abort_out_valid", 256'(out_valid), 256'(0));
        chk("abort_busy", 256'(busy), 256'(1));
        chk("abort_idx", 256'(out_row_idx), 256'(0));
        chk("abort_pixels", out_pixels, 256'(0));
        ready_fixed = 1'b1;
        feed(0, 32, 1'b0);
        wait_idle();

        // Asynchronous reset during a stalled row.
        ready_fixed = 1'b0;
        start_block(2, 1'b1, 1'b0);
        feed(0, 20, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_pre_valid", 256'(out_valid), 256'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_in_ready", 256'(in_ready), 256'(0));
            chk("post_rst_busy", 256'(busy), 256'(0));
        end
        in_valid    = 1'b0;
        ready_fixed = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
